// File: rtl/prog_counter.sv
// prog_counter -- programmable up/down counter with a tick prescaler.
//
// A start pulse captures the configuration (term, prescale, oneshot, down)
// into shadow registers and begins counting. The counter advances once every
// prescale+1 clocks. When it reaches its end value it emits a one-clock strobe.
// It then either reloads and keeps running (periodic mode) or parks in DONE
// (one-shot mode).
//
// Parameters:
//   DW        counter width in bits
//   PW        prescaler width in bits
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-high reset
//   start     one-cycle pulse: capture config, load start value, enter RUN
//   stop      one-cycle pulse: abort to IDLE (wins over start)
//   oneshot   1 = stop after first terminal event, 0 = periodic
//   down      1 = count term..0, 0 = count 0..term
//   term      terminal value
//   prescale  tick divider, one step every prescale+1 clocks
//   cntr      current count (registered)
//   strb      one-clock pulse per terminal event (registered)
//   busy      high while in RUN
//   done      sticky one-shot completion flag (state == DONE)

module prog_counter #(
    parameter int DW = 12,
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          stop,
    input  logic          oneshot,
    input  logic          down,
    input  logic [DW-1:0] term,
    input  logic [PW-1:0] prescale,
    output logic [DW-1:0] cntr,
    output logic          strb,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [DW-1:0] cntr_n;
    logic [PW-1:0] presc, presc_n;
    logic          strb_n;

    logic [DW-1:0] term_q, term_n;
    logic [PW-1:0] prescale_q, prescale_n;
    logic          oneshot_q, oneshot_n;
    logic          down_q, down_n;

    logic          tick;
    logic [DW-1:0] start_val;
    logic [DW-1:0] end_val;

    // Start and end values come from the shadow copies, so input changes
    // during a run have no effect until the next start.
    assign tick      = (presc == prescale_q);
    assign start_val = down_q ? term_q : '0;
    assign end_val   = down_q ? '0 : term_q;

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // Register all state. Reset clears everything, including the shadows.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cntr       <= '0;
            presc      <= '0;
            strb       <= 1'b0;
            term_q     <= '0;
            prescale_q <= '0;
            oneshot_q  <= 1'b0;
            down_q     <= 1'b0;
        end else begin
            state      <= state_n;
            cntr       <= cntr_n;
            presc      <= presc_n;
            strb       <= strb_n;
            term_q     <= term_n;
            prescale_q <= prescale_n;
            oneshot_q  <= oneshot_n;
            down_q     <= down_n;
        end
    end

    // Next-state logic. Priority is stop, then start, then normal RUN
    // activity. strb defaults to 0, so it is a single-clock pulse that
    // only a terminal tick raises.
    always_comb begin
        state_n    = state;
        cntr_n     = cntr;
        presc_n    = presc;
        strb_n     = 1'b0;
        term_n     = term_q;
        prescale_n = prescale_q;
        oneshot_n  = oneshot_q;
        down_n     = down_q;

        if (stop) begin
            state_n = IDLE;
            presc_n = '0;
        end else if (start) begin
            // The shadows are not written yet on this edge, so the start
            // value is taken directly from the inputs.
            term_n     = term;
            prescale_n = prescale;
            oneshot_n  = oneshot;
            down_n     = down;
            cntr_n     = down ? term : '0;
            presc_n    = '0;
            state_n    = RUN;
        end else if (state == RUN) begin
            if (tick) begin
                presc_n = '0;
                if (cntr == end_val) begin
                    strb_n = 1'b1;
                    if (oneshot_q) begin
                        state_n = DONE;
                    end else begin
                        cntr_n = start_val;
                    end
                end else if (down_q) begin
                    cntr_n = cntr - DW'(1);
                end else begin
                    cntr_n = cntr + DW'(1);
                end
            end else begin
                presc_n = presc + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_prog_counter.sv
// tb_prog_counter -- directed self-checking bench for prog_counter.
// Inputs change 1 time unit after a rising edge. Outputs are sampled at the
// same point, which is away from the active edge.

module tb_prog_counter;

    localparam int DW = 12;
    localparam int PW = 8;

    logic          clk;
    logic          reset;
    logic          start;
    logic          stop;
    logic          oneshot;
    logic          down;
    logic [DW-1:0] term;
    logic [PW-1:0] prescale;
    logic [DW-1:0] cntr;
    logic          strb;
    logic          busy;
    logic          done;

    int compared;
    int mismatched;

    prog_counter #(.DW(DW), .PW(PW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .oneshot  (oneshot),
        .down     (down),
        .term     (term),
        .prescale (prescale),
        .cntr     (cntr),
        .strb     (strb),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle 1 time unit past the rising edge.
    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    // Apply one clock with the given start/stop pulses, then drop them.
    task automatic applyStimulus(input logic s, input logic p);
        start = s;
        stop  = p;
        stepClk();
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [DW-1:0] exp_cntr,
                               input logic exp_strb, input logic exp_busy,
                               input logic exp_done);
        compared++;
        assert (cntr === exp_cntr && strb === exp_strb && busy === exp_busy && done === exp_done)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: got cntr=%0d strb=%0b busy=%0b done=%0b, expected cntr=%0d strb=%0b busy=%0b done=%0b",
                   tag, cntr, strb, busy, done, exp_cntr, exp_strb, exp_busy, exp_done);
        end
    endtask

    int exp_down [13] = '{2, 2, 1, 1, 0, 0, 2, 2, 1, 1, 0, 0, 2};

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        start      = 1'b0;
        stop       = 1'b0;
        oneshot    = 1'b0;
        down       = 1'b0;
        term       = '0;
        prescale   = '0;

        // Reset state
        #12;
        checkOutput("reset", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        stepClk();
        checkOutput("idle_after_reset", 0, 0, 0, 0);

        // Periodic up, term=3, prescale=0. term changes mid-run and must be ignored.
        term = 3;
        applyStimulus(1'b1, 1'b0);
        checkOutput("up_start", 0, 0, 1, 0);
        term = 7;
        for (int i = 1; i <= 6; i++) begin
            stepClk();
            checkOutput($sformatf("up_step%0d", i), DW'(i % 4), (i % 4) == 0, 1, 0);
        end

        // Stop holds cntr (2) and leaves RUN.
        applyStimulus(1'b0, 1'b1);
        checkOutput("stop", 2, 0, 0, 0);
        stepClk();
        checkOutput("stop_hold", 2, 0, 0, 0);

        // Periodic down, term=2, prescale=1: 2,2,1,1,0,0,2,...
        down = 1'b1;
        term = 2;
        prescale = 1;
        applyStimulus(1'b1, 1'b0);
        checkOutput("down_start", 2, 0, 1, 0);
        for (int i = 1; i <= 12; i++) begin
            stepClk();
            checkOutput($sformatf("down_step%0d", i), DW'(exp_down[i]), (i % 6) == 0, 1, 0);
        end

        // Restart mid-run: after 2 more clocks cntr=1, then a restart reloads 2.
        stepClk();
        stepClk();
        checkOutput("down_pre_restart", 1, 0, 1, 0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("restart", 2, 0, 1, 0);
        for (int i = 1; i <= 6; i++) begin
            stepClk();
            checkOutput($sformatf("restart_step%0d", i), DW'(exp_down[i]), i == 6, 1, 0);
        end

        // One-shot, term=5: a single strb 6 clocks after start, then DONE at 5.
        down = 1'b0;
        oneshot = 1'b1;
        term = 5;
        prescale = 0;
        applyStimulus(1'b1, 1'b0);
        checkOutput("os_start", 0, 0, 1, 0);
        for (int i = 1; i <= 5; i++) begin
            stepClk();
            checkOutput($sformatf("os_step%0d", i), DW'(i), 0, 1, 0);
        end
        stepClk();
        checkOutput("os_terminal", 5, 1, 0, 1);
        stepClk();
        checkOutput("os_done_hold", 5, 0, 0, 1);

        // A new start from DONE clears done.
        oneshot = 1'b0;
        term = 1;
        applyStimulus(1'b1, 1'b0);
        checkOutput("start_from_done", 0, 0, 1, 0);

        // Simultaneous start and stop: stop wins, cntr held, no strb.
        applyStimulus(1'b1, 1'b1);
        checkOutput("start_stop", 0, 0, 0, 0);
        stepClk();
        checkOutput("start_stop_idle", 0, 0, 0, 0);

        // term=0, prescale=0: cntr stays 0 and strb fires every clock.
        term = 0;
        applyStimulus(1'b1, 1'b0);
        checkOutput("t0_start", 0, 0, 1, 0);
        for (int i = 1; i <= 3; i++) begin
            stepClk();
            checkOutput($sformatf("t0_step%0d", i), 0, 1, 1, 0);
        end

        // term=0, prescale=1: strb on every second clock.
        prescale = 1;
        applyStimulus(1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            stepClk();
            checkOutput($sformatf("t0p1_step%0d", i), 0, (i % 2) == 0, 1, 0);
        end

        // Reset mid-run, asserted between edges.
        term = 3;
        prescale = 0;
        applyStimulus(1'b1, 1'b0);
        stepClk();
        stepClk();
        checkOutput("pre_reset", 2, 0, 1, 0);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("async_reset", 0, 0, 0, 0);
        #2;
        reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            stepClk();
            checkOutput($sformatf("post_reset%0d", i), 0, 0, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/prog_counter.md
PROG_COUNTER -- requirements
Module: prog_counter

Interface
REQ-001 The block SHALL have parameter DW, default 12, counter width in bits.
REQ-002 The block SHALL have parameter PW, default 8, prescaler width in bits.
REQ-003 The block SHALL have port clk, input, 1, system clock; all flops on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, one-cycle pulse: capture config and begin counting.
REQ-006 The block SHALL have port stop, input, 1, one-cycle pulse: abort counting.
REQ-007 The block SHALL have port oneshot, input, 1, 1 = stop after the first terminal event, 0 = periodic.
REQ-008 The block SHALL have port down, input, 1, 1 = count down from term to 0, 0 = count up from 0 to term.
REQ-009 The block SHALL have port term, input, DW, terminal value.
REQ-010 The block SHALL have port prescale, input, PW, tick divider: one count step every prescale+1 clocks.
REQ-011 The block SHALL have port cntr, output, DW, current count (registered).
REQ-012 The block SHALL have port strb, output, 1, one-clock pulse per terminal event (registered).
REQ-013 The block SHALL have port busy, output, 1, high while in RUN.
REQ-014 The block SHALL have port done, output, 1, sticky one-shot completion flag.

Function
REQ-015 The block SHALL implement states IDLE, RUN and DONE, with busy = (state == RUN) and done = (state == DONE).
REQ-016 On start, the block SHALL latch term, prescale, oneshot and down into shadow registers; later input changes SHALL be ignored until the next start.
REQ-017 The start value SHALL be 0 when down = 0 and term when down = 1; the end value SHALL be term when down = 0 and 0 when down = 1 (shadow values).
REQ-018 On the edge sampling start, the block SHALL go to RUN, load cntr with the start value and clear the prescaler; this SHALL apply from IDLE, RUN (restart) and DONE.
REQ-019 Tick generation: in RUN the prescaler SHALL count 0..prescale_q, wrap to 0 and assert an internal tick on the clock where it equals prescale_q; prescale_q = 0 SHALL give a tick every clock.
REQ-020 On a tick with cntr != end value, cntr SHALL step by one (+1 up, -1 down).
REQ-021 On a tick with cntr == end value, the block SHALL set strb = 1 for exactly one clock on the same edge.
REQ-022 On that same terminal tick in periodic mode, cntr SHALL reload the start value and the block SHALL stay in RUN.
REQ-023 On that same terminal tick in one-shot mode, the block SHALL go to DONE with cntr holding the end value.
REQ-024 The terminal period SHALL be (term_q+1)*(prescale_q+1) clocks; the first strb SHALL occur that many clocks after the start edge.
REQ-025 term_q = 0 SHALL keep cntr at 0 and assert strb on every tick.
REQ-026 No count step SHALL wrap past 0 or 2^DW-1; reload SHALL happen only at the end value.
REQ-027 stop SHALL move the block to IDLE, hold cntr, clear the prescaler and suppress strb on that edge.
REQ-028 When start and stop are asserted in the same cycle, stop SHALL take priority.
REQ-029 In IDLE and DONE, cntr and the prescaler SHALL hold and strb SHALL be 0.

Reset
REQ-030 reset SHALL asynchronously force state = IDLE, cntr = 0, prescaler = 0, strb = 0, busy = 0, done = 0 and all shadow registers = 0.
REQ-031 When reset is asserted mid-RUN, the block SHALL abort immediately with no strb emitted; after deassertion the block SHALL stay in IDLE until the next start.

Verification
REQ-032 Periodic up: term = 3, prescale = 0, start -> cntr 0,1,2,3,0,...; strb every 4 clocks, first 4 clocks after start.
REQ-033 Periodic down with prescaler: down = 1, term = 2, prescale = 1 -> cntr 2,2,1,1,0,0,2; strb every 6 clocks.
REQ-034 One-shot: oneshot = 1, term = 5 -> a single strb 6 clocks after start, then busy = 0, done = 1, cntr = 5; a new start clears done.
REQ-035 Config isolation and restart: change term mid-run -> period unchanged; re-start mid-run -> cntr reloads and the period restarts from that edge.
REQ-036 Simultaneous start and stop -> IDLE, no strb; term = 0 -> strb every tick.
REQ-037 Reset mid-run: assert reset asynchronously between edges -> all outputs 0 immediately; no activity until the next start.
